// File: rtl/demux_rr_dispatcher.sv
// Round-robin dispatcher feeding a 4-way demultiplexer.
// Accepts a valid/ready word stream and assigns each word to the next
// enabled channel, starting the search at a rotating pointer. The output
// word and its select are registered. A one-word skid register lets in_ready
// come straight from a flop while still sustaining one word per clock.
module demux_rr_dispatcher #(
  parameter int BUS_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BUS_WIDTH-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           ch_en,
  input  logic [3:0]           ch_ready,
  output logic [BUS_WIDTH-1:0] y,
  output logic [1:0]           sel,
  output logic                 y_valid,
  output logic [CNT_WIDTH-1:0] xfer_cnt
);

  logic [BUS_WIDTH-1:0] skid_data;
  logic                 skid_valid;
  logic [1:0]           ptr;
  logic [1:0]           nxt;

  logic accept;
  logic drain;
  logic load_ok;
  logic load_skid;
  logic load_in;

  // in_ready depends only on the skid flop, so there is no combinational
  // path from ch_ready or in_valid back to the upstream source.
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready;
  assign drain     = y_valid & ch_ready[sel];
  assign load_ok   = (~y_valid | drain) & (ch_en != 4'b0000);
  // The skid word is older than anything upstream, so it loads first.
  assign load_skid = load_ok & skid_valid;
  assign load_in   = load_ok & ~skid_valid & accept;

  // Pick the first enabled channel at or after the round-robin pointer.
  always_comb begin
    logic [1:0] idx;
    logic       found;
    // NOTE: every variable gets a default before any conditional write;
    // a path that leaves one unassigned would infer a latch.
    nxt   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && ch_en[idx]) begin
        nxt   = idx;
        found = 1'b1;
      end
    end
  end

  // Output register, skid register and round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: reset is tested inside the clocked block, so it only takes
    // effect on a rising edge; every flop here gets an explicit value.
    if (!rst_n) begin
      y          <= '0;
      sel        <= 2'd0;
      y_valid    <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      ptr        <= 2'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the
      // pre-edge values, regardless of statement order.
      if (load_skid) begin
        y          <= skid_data;
        sel        <= nxt;
        y_valid    <= 1'b1;
        skid_valid <= 1'b0;
        ptr        <= nxt + 2'd1;
      end else if (load_in) begin
        y       <= in_data;
        sel     <= nxt;
        y_valid <= 1'b1;
        ptr     <= nxt + 2'd1;
      end else if (drain) begin
        // sel keeps its last value so the demux select does not glitch.
        y       <= '0;
        y_valid <= 1'b0;
      end

      // Park an accepted word that cannot go straight to the output.
      if (accept && !load_ok) begin
        skid_data  <= in_data;
        skid_valid <= 1'b1;
      end
    end
  end

  // Count every word the consumer takes; wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (drain) begin
      xfer_cnt <= xfer_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_demux_rr_dispatcher.sv
// Bench for demux_rr_dispatcher. Stimulus pushes the hand-computed
// {data, sel} of every word into a queue; a monitor pops and compares each
// time the DUT hands a word to a ready channel.
module tb_demux_rr_dispatcher;

  localparam int BW = 8;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic [BW-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    ch_en;
  logic [3:0]    ch_ready;
  logic [BW-1:0] y;
  logic [1:0]    sel;
  logic          y_valid;
  logic [CW-1:0] xfer_cnt;

  int n_vec  = 0;
  int n_fail = 0;

  logic [BW+1:0] exp_q[$];

  demux_rr_dispatcher #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ch_en    (ch_en),
    .ch_ready (ch_ready),
    .y        (y),
    .sel      (sel),
    .y_valid  (y_valid),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a word leaves at the next rising edge when it is valid and its
  // channel is ready; sample on the falling edge while everything is stable.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && y_valid === 1'b1 && ch_ready[sel] === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_word: got y=%0h sel=%0d expected no word", y, sel);
      end else begin
        logic [BW+1:0] e;
        e = exp_q.pop_front();
        check("drain_word", 32'({y, sel}), 32'(e));
      end
    end
  end

  // Offer one word and hold it until accepted (bounded wait).
  task automatic send(input logic [BW-1:0] d, input logic [1:0] s);
    int  n;
    bit  done;
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back({d, s});
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 50) begin
        n_vec++;
        n_fail++;
        $display("FAIL accept_timeout: got no accept for %0h expected accept", d);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Wait until all expected words have drained and the output is empty.
  task automatic wait_idle();
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (exp_q.size() == 0 && y_valid == 1'b0) done = 1'b1;
      @(posedge clk);
      #1;
      n++;
      if (!done && n > 100) begin
        n_vec++;
        n_fail++;
        $display("FAIL idle_timeout: got %0d words pending expected 0", exp_q.size());
        done = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h99;
    ch_en    = 4'hF;
    ch_ready = 4'hF;

    // Reset held two cycles with a word offered: nothing may be taken.
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_y", 32'(y), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_y_valid", 32'(y_valid), 32'h0);
    check("rst_xfer_cnt", 32'(xfer_cnt), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_nothing_accepted", 32'(y_valid), 32'h0);
    @(posedge clk);
    #1;

    // Streaming: one word per clock, sel rotates 0..3, one cycle latency.
    for (int i = 0; i < 8; i++) begin
      in_data  = 8'h11 + 8'(i);
      in_valid = 1'b1;
      exp_q.push_back({8'h11 + 8'(i), 2'(i % 4)});
      @(negedge clk);
      check("stream_in_ready", 32'(in_ready), 32'h1);
      if (i > 0) check("stream_latency", 32'(y), 32'h11 + 32'(i - 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_idle();
    check("stream_xfer_cnt", 32'(xfer_cnt), 32'd8);

    // Skip disabled channels, then retarget mid-stream.
    ch_en = 4'b0101;
    send(8'h21, 2'd0);
    send(8'h22, 2'd2);
    send(8'h23, 2'd0);
    send(8'h24, 2'd2);
    ch_en = 4'b1000;
    send(8'h25, 2'd3);
    send(8'h26, 2'd3);
    wait_idle();
    check("skip_xfer_cnt", 32'(xfer_cnt), 32'd14);

    // Backpressure: output holds, skid fills, third word waits upstream.
    ch_en    = 4'hF;
    ch_ready = 4'h0;
    send(8'hA1, 2'd0);
    send(8'hA2, 2'd1);
    in_data  = 8'hA3;
    in_valid = 1'b1;
    exp_q.push_back({8'hA3, 2'd2});
    repeat (3) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("bp_y_held", 32'(y), 32'hA1);
    check("bp_y_valid", 32'(y_valid), 32'h1);
    check("bp_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    ch_ready = 4'hF;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_skid_next", 32'({y, sel}), 32'({8'hA2, 2'd1}));
    check("bp_accept_a3", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();
    check("bp_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // All channels disabled: first word parks in skid, second waits.
    ch_en = 4'h0;
    send(8'h55, 2'd1);
    in_data  = 8'h66;
    in_valid = 1'b1;
    exp_q.push_back({8'h66, 2'd1});
    @(negedge clk);
    check("dis_y_valid", 32'(y_valid), 32'h0);
    check("dis_in_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    ch_en = 4'b0010;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("dis_first_out", 32'({y, sel}), 32'({8'h55, 2'd1}));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();
    check("dis_xfer_cnt", 32'(xfer_cnt), 32'd3);

    // Counter wrap: 17 drains on a 4-bit counter from reset leaves 1.
    ch_en = 4'hF;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'h80 + 8'(i), 2'(i % 4));
    end
    wait_idle();
    check("wrap_xfer_cnt", 32'(xfer_cnt), 32'd1);

    // Reset mid-operation with output and skid both occupied.
    ch_ready = 4'h0;
    send(8'hB1, 2'd1);
    send(8'hB2, 2'd2);
    @(negedge clk);
    check("mid_y_before", 32'({y, sel}), 32'({8'hB1, 2'd1}));
    check("mid_skid_full", 32'(in_ready), 32'h0);
    @(posedge clk);
    #1;
    do_reset();
    @(negedge clk);
    check("mid_rst_y_valid", 32'(y_valid), 32'h0);
    check("mid_rst_y", 32'(y), 32'h0);
    check("mid_rst_sel", 32'(sel), 32'h0);
    check("mid_rst_cnt", 32'(xfer_cnt), 32'h0);
    check("mid_rst_in_ready", 32'(in_ready), 32'h1);
    @(posedge clk);
    #1;
    ch_ready = 4'hF;
    repeat (5) begin
      @(negedge clk);
      check("mid_no_stale", 32'(y_valid), 32'h0);
      @(posedge clk);
      #1;
    end
    send(8'hC1, 2'd0);
    wait_idle();
    check("mid_after_cnt", 32'(xfer_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
Upstream feeder for the 4-way n-bit demultiplexer. Accepts a valid/ready data stream and assigns each word round-robin to one of four output channels, skipping disabled channels. Drives the demux's data bus (y) and select (sel) from registers, with a 2-deep buffer (output register plus skid register) so it sustains one word per clock when the target channel is ready.

Parameters:
BUS_WIDTH, 8, width of data word (matches demux bus width)
CNT_WIDTH, 16, width of dispatched-word counter

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
in_data  input  BUS_WIDTH  upstream data word
in_valid  input  1  upstream word present
in_ready  output  1  dispatcher can accept a word this cycle
ch_en  input  4  per-channel enable; bit i set = channel i eligible for assignment
ch_ready  input  4  per-channel consumer ready; bit i pairs with sel==i
y  output  BUS_WIDTH  data to demux input y
sel  output  2  channel select to demux sel
y_valid  output  1  y/sel hold a word not yet consumed
xfer_cnt  output  CNT_WIDTH  total words dispatched, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (rst_n low at edge): y=0, sel=0, y_valid=0, skid empty, rr pointer ptr=0, xfer_cnt=0. Inputs ignored while rst_n low. Reset mid-transfer discards output and skid words.
- in_ready = ~skid_valid (from flop, no combinational path from ch_ready/in_valid).
- accept = in_valid & in_ready. drain = y_valid & ch_ready[sel].
- load_ok = (~y_valid | drain) & (ch_en != 0).
- nxt = first channel i with ch_en[i]=1, searching ptr, ptr+1, ... wrapping mod 4.
- Each cycle, in priority order:
  - load_ok & skid_valid: y<=skid_data, sel<=nxt, y_valid<=1, skid cleared, ptr<=nxt+1 (mod 4).
  - load_ok & ~skid_valid & accept: y<=in_data, sel<=nxt, y_valid<=1, ptr<=nxt+1.
  - ~load_ok & accept: in_data stored in skid (skid empty guaranteed by in_ready).
  - drain with no load: y_valid<=0, y<=0 (sel holds last value).
- Latency: a word accepted at edge N with output empty or draining and ch_en!=0 is on y/sel with y_valid=1 after edge N (1 cycle).
- While y_valid=1 and not drained, y and sel are stable; ch_en changes affect only subsequent assignments.
- ch_en=0: no loads; held output word still drains normally; one further word is buffered in skid, then in_ready=0.
- Word order preserved; no word dropped or duplicated.
- xfer_cnt increments by 1 on every drain; wraps all-ones -> 0.
- Throughput: 1 word/cycle when ch_ready[sel]=1 every cycle.

Test Plan:
- Reset: hold rst_n=0 2 cycles with in_valid=1 -> y=0, sel=0, y_valid=0, xfer_cnt=0, in_ready=1 after release, nothing accepted.
- Streaming: ch_en=4'hF, ch_ready=4'hF, words 0x11..0x18 on consecutive cycles -> y follows 1 cycle later, sel 0,1,2,3,0,1,2,3, in_ready stays 1, xfer_cnt=8.
- Skip: ch_en=4'b0101, 4 words -> sel 0,2,0,2; ch_en changed to 4'b1000 mid-stream -> next sel=3 repeatedly.
- Backpressure: ch_ready=0 while sending 0xA1,0xA2,0xA3 -> y=0xA1 held, 0xA2 in skid, in_ready=0, 0xA3 held upstream; ch_ready=4'hF -> 0xA1,0xA2,0xA3 drain on consecutive cycles in order.
- All disabled: ch_en=0, send 0x55,0x66 -> y_valid=0, skid holds 0x55, in_ready=0; ch_en=4'b0010 -> y=0x55 sel=1, then 0x66 sel=1.
- Counter wrap/reset mid-op: CNT_WIDTH=4, 17 drains -> xfer_cnt=1; assert rst_n low with y_valid=1 and skid full -> all state cleared next cycle, no stale word appears afterward.
